// File: rtl/common_axi_mem_responder_if.sv
// Combined-address AXI bus (Efinix style: atype selects write/read) between a
// traffic initiator and common_axi_mem_responder.
interface common_axi_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic [7:0]         aid;
  logic [31:0]        aaddr;
  logic [7:0]         alen;
  logic [2:0]         asize;
  logic [1:0]         aburst;
  logic [1:0]         alock;
  logic               atype;
  logic               avalid;
  logic               aready;

  logic [7:0]         wid;
  logic [WIDTH-1:0]   wdata;
  logic [WIDTH/8-1:0] wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;

  logic [7:0]         bid;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;

  logic [3:0]         rid;
  logic [WIDTH-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rlast;
  logic               rvalid;
  logic               rready;

  modport master (
    output aid, aaddr, alen, asize, aburst, alock, atype, avalid,
    input  aready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  aid, aaddr, alen, asize, aburst, alock, atype, avalid,
    output aready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/common_axi_mem_responder.sv
// Single-outstanding AXI responder backed by a 2^DEPTH_LOG2 x WIDTH RAM.
// Optional handshake stalling via LFSR when COMMON_AXI_MEM_RESP_STALL_EN is defined.
module common_axi_mem_responder #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input logic                      axi_clk,
  input logic                      rst,
  common_axi_mem_responder_if.slave bus
);
  localparam int NB    = WIDTH / 8;
  localparam int S     = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  state_e                state_q;
  logic                  aready_q, wready_q, bvalid_q;
  logic [7:0]            id_q, bid_q, len_q, beat_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [3:0]            rid_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  incr_q, burst_err_q, wlast_err_q;
  logic [8:0]            rd_left_q;
  logic                  inflight_q, inflight_last_q;
  logic [WIDTH-1:0]      dout_q;
  logic [WIDTH-1:0]      buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  buf_wp_q, buf_rp_q;
  logic [1:0]            buf_cnt_q;
  logic [WIDTH-1:0]      mem [DEPTH];

  logic stall_hs, stall_rd;
`ifdef COMMON_AXI_MEM_RESP_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge axi_clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall_hs = ~lfsr_q[0];
  assign stall_rd = ~lfsr_q[1];
`else
  assign stall_hs = 1'b0;
  assign stall_rd = 1'b0;
`endif

  logic a_hs, w_hs, b_hs, w_last_beat, w_last_bad;
  logic rd_issue, rvalid, buf_empty, push, pop_buf, r_pop;
  logic [WIDTH-1:0] rd_word;

  assign bus.aready  = aready_q & ~stall_hs;
  assign bus.wready  = wready_q & ~stall_hs;
  assign a_hs        = bus.avalid & bus.aready;
  assign w_hs        = bus.wvalid & bus.wready;
  assign b_hs        = bvalid_q & bus.bready;
  assign w_last_beat = (beat_q == len_q);
  assign w_last_bad  = (bus.wlast != w_last_beat);

  // Issue only while buffer slots plus the in-flight RAM read leave room for the result.
  assign rd_issue  = (state_q == RDATA) && (rd_left_q != 9'd0) &&
                     ((buf_cnt_q + {1'b0, inflight_q}) < 2'd2) && !stall_rd;
  assign buf_empty = (buf_cnt_q == 2'd0);
  assign rvalid    = !buf_empty || inflight_q;
  assign r_pop     = rvalid && bus.rready;
  // RAM output bypasses the empty buffer; it is parked only when not taken this cycle.
  assign push      = inflight_q && !(buf_empty && bus.rready);
  assign pop_buf   = r_pop && !buf_empty;
  assign rd_word   = burst_err_q ? '0 : dout_q;

  assign bus.rvalid = rvalid;
  assign bus.rdata  = !buf_empty ? buf_data_q[buf_rp_q] : (inflight_q ? rd_word : '0);
  assign bus.rlast  = !buf_empty ? buf_last_q[buf_rp_q] : (inflight_q & inflight_last_q);
  assign bus.rid    = rid_q;
  assign bus.rresp  = rresp_q;
  assign bus.bvalid = bvalid_q;
  assign bus.bid    = bid_q;
  assign bus.bresp  = bresp_q;

  logic unused_ok;
  assign unused_ok = ^{bus.asize, bus.alock, bus.wid, bus.aaddr};

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axi_clk) begin
    if (rst) begin
      state_q         <= IDLE;
      aready_q        <= 1'b0;
      wready_q        <= 1'b0;
      bvalid_q        <= 1'b0;
      bid_q           <= '0;
      bresp_q         <= RESP_OKAY;
      rid_q           <= '0;
      rresp_q         <= RESP_OKAY;
      id_q            <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      idx_q           <= '0;
      incr_q          <= 1'b0;
      burst_err_q     <= 1'b0;
      wlast_err_q     <= 1'b0;
      rd_left_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_last_q      <= '0;
      buf_wp_q        <= 1'b0;
      buf_rp_q        <= 1'b0;
      buf_cnt_q       <= '0;
    end else begin
      inflight_q <= rd_issue;
      if (rd_issue) begin
        inflight_last_q <= (rd_left_q == 9'd1);
        rd_left_q       <= rd_left_q - 9'd1;
        if (incr_q) idx_q <= idx_q + DEPTH_LOG2'(1);
      end
      if (push) begin
        buf_last_q[buf_wp_q] <= inflight_last_q;
        buf_wp_q             <= ~buf_wp_q;
      end
      if (pop_buf) buf_rp_q <= ~buf_rp_q;
      buf_cnt_q <= buf_cnt_q + {1'b0, push} - {1'b0, pop_buf};

      unique case (state_q)
        IDLE: begin
          aready_q <= 1'b1;
          if (a_hs) begin
            aready_q    <= 1'b0;
            id_q        <= bus.aid;
            idx_q       <= bus.aaddr[DEPTH_LOG2+S-1:S];
            len_q       <= bus.alen;
            beat_q      <= '0;
            incr_q      <= (bus.aburst == 2'b01);
            burst_err_q <= bus.aburst[1];
            wlast_err_q <= 1'b0;
            if (bus.atype) begin
              wready_q <= 1'b1;
              state_q  <= WDATA;
            end else begin
              rid_q     <= bus.aid[3:0];
              rresp_q   <= bus.aburst[1] ? RESP_SLVERR : RESP_OKAY;
              rd_left_q <= {1'b0, bus.alen} + 9'd1;
              state_q   <= RDATA;
            end
          end
        end
        WDATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 8'd1;
            if (incr_q) idx_q <= idx_q + DEPTH_LOG2'(1);
            if (w_last_bad) wlast_err_q <= 1'b1;
            // The beat count, not wlast, closes the data phase.
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (burst_err_q || wlast_err_q || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= WRESP;
            end
          end
        end
        WRESP: begin
          if (b_hs) begin
            bvalid_q <= 1'b0;
            aready_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        RDATA: begin
          if (r_pop && bus.rlast) begin
            aready_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: RAM array and data-only registers carry no reset so they map onto block RAM.
  always_ff @(posedge axi_clk) begin
    if (!rst && state_q == WDATA && w_hs && !burst_err_q) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wstrb[b]) mem[idx_q][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
    end
    if (rd_issue) dout_q <= mem[idx_q];
    if (push) buf_data_q[buf_wp_q] <= rd_word;
  end
endmodule
